my_pipelined_rightshifter: RTL and testbench

- 5-stage pipelined 32-bit right barrel shifter, logical (SRL) and arithmetic (SRA); the right-shift counterpart to the existing left-shift stages in the execute path.
- Each stage conditionally shifts by one power of two: 16, 8, 4, 2, 1.
- Valid/ready handshake on both ends, global stall, and a synchronous flush for branch mispredict squashes.

---
 rtl/my_pipelined_rightshifter.sv | 161 ++++++++++++++++
 tb/tb_my_pipelined_rightshifter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/my_pipelined_rightshifter.sv
// my_pipelined_rightshifter
// Five-stage pipelined 32-bit right barrel shifter supporting logical (zero
// fill) and arithmetic (sign fill) shifts. Stage S1 shifts by 16, S2 by 8,
// S3 by 4, S4 by 2 and S5 by 1, each only when its shift-amount bit is set.
// Each stage carries only the shift-amount bits still to be consumed.
// A single "advance" signal moves the whole pipeline forward together.
// Backpressure from out_ready freezes every stage at once. A flush squashes
// every in-flight operation without touching the data fields.
module my_pipelined_rightshifter #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  data_input,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic                   arith,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  data_output
);

    // One conditional shift step. The fill bit comes from the current MSB.
    // The MSB never changes under sign fill, so it is always the original
    // operand sign bit.
    function automatic logic [DATA_WIDTH-1:0] shift_step(
        input logic [DATA_WIDTH-1:0] d,
        input logic                  en,
        input logic                  ar,
        input int unsigned           amt
    );
        logic [DATA_WIDTH-1:0] fill_mask;
        logic [DATA_WIDTH-1:0] result;
        fill_mask = ~({DATA_WIDTH{1'b1}} >> amt);
        result    = d;
        if (en) begin
            result = (d >> amt) | ((ar && d[DATA_WIDTH-1]) ? fill_mask : '0);
        end
        return result;
    endfunction

    // Stage registers: valid bit, partially shifted data, the shift-amount
    // bits still to be applied downstream, and the fill mode.
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [3:0]            s1_shamt;
    logic                  s1_arith;

    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_data;
    logic [2:0]            s2_shamt;
    logic                  s2_arith;

    logic                  s3_valid;
    logic [DATA_WIDTH-1:0] s3_data;
    logic [1:0]            s3_shamt;
    logic                  s3_arith;

    logic                  s4_valid;
    logic [DATA_WIDTH-1:0] s4_data;
    logic                  s4_shamt;
    logic                  s4_arith;

    logic                  s5_valid;
    logic [DATA_WIDTH-1:0] s5_data;

    // Combinational shift results feeding each stage register.
    logic [DATA_WIDTH-1:0] s1_next;
    logic [DATA_WIDTH-1:0] s2_next;
    logic [DATA_WIDTH-1:0] s3_next;
    logic [DATA_WIDTH-1:0] s4_next;
    logic [DATA_WIDTH-1:0] s5_next;

    logic advance;

    // The pipeline moves whenever the output slot is empty or being drained.
    // This gives the only combinational path, from out_ready to in_ready.
    always_comb begin
        advance  = !s5_valid || out_ready;
        in_ready = advance;
    end

    // Compute the per-stage shift amounts: 16, 8, 4, 2, then 1.
    always_comb begin
        s1_next = shift_step(data_input, shamt[SHAMT_WIDTH-1], arith, 16);
        s2_next = shift_step(s1_data, s1_shamt[3], s1_arith, 8);
        s3_next = shift_step(s2_data, s2_shamt[2], s2_arith, 4);
        s4_next = shift_step(s3_data, s3_shamt[1], s3_arith, 2);
        s5_next = shift_step(s4_data, s4_shamt, s4_arith, 1);
    end

    // Valid-bit pipeline.
    // Reset beats flush, and flush beats advance or hold.
    // On a flush, the input presented in that cycle is discarded.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s4_valid <= 1'b0;
            s5_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s4_valid <= 1'b0;
            s5_valid <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            s4_valid <= s3_valid;
            s5_valid <= s4_valid;
        end
    end

    // Data, shift-amount and mode pipeline.
    // These fields are not cleared by flush, because the valid bits alone
    // decide whether a stage holds anything meaningful.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_data  <= '0;
            s1_shamt <= '0;
            s1_arith <= 1'b0;
            s2_data  <= '0;
            s2_shamt <= '0;
            s2_arith <= 1'b0;
            s3_data  <= '0;
            s3_shamt <= '0;
            s3_arith <= 1'b0;
            s4_data  <= '0;
            s4_shamt <= 1'b0;
            s4_arith <= 1'b0;
            s5_data  <= '0;
        end else if (!flush && advance) begin
            s1_data  <= s1_next;
            s1_shamt <= shamt[3:0];
            s1_arith <= arith;
            s2_data  <= s2_next;
            s2_shamt <= s1_shamt[2:0];
            s2_arith <= s1_arith;
            s3_data  <= s3_next;
            s3_shamt <= s2_shamt[1:0];
            s3_arith <= s2_arith;
            s4_data  <= s4_next;
            s4_shamt <= s3_shamt[0];
            s4_arith <= s3_arith;
            s5_data  <= s5_next;
        end
    end

    // The last stage is the output register.
    always_comb begin
        out_valid   = s5_valid;
        data_output = s5_data;
    end

endmodule

// File: tb/tb_my_pipelined_rightshifter.sv
// tb_my_pipelined_rightshifter
// Drives directed and random shift operations into the pipelined right
// shifter. An in-order queue of expected results is built from plain >> and
// >>> arithmetic, and the queue is compared against the output handshakes.
module tb_my_pipelined_rightshifter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] data_input = '0;
    logic [4:0]  shamt = '0;
    logic        arith = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] data_output;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    int          results_seen = 0;
    bit          lat_check = 1'b0;
    logic [31:0] exp_q[$];
    int          acc_q[$];

    my_pipelined_rightshifter dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_input (data_input),
        .shamt      (shamt),
        .arith      (arith),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_output(data_output)
    );

    // Free-running clock with a 10-unit period.
    always #5 clock = ~clock;

    // Single comparison point; every check counts here.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp_val);
        tests_run++;
        if (got !== exp_val) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp_val, cyc);
        end
    endtask

    // Reference shift computed directly from the arithmetic meaning.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s, input logic a);
        logic signed [31:0] sd;
        sd = d;
        if (a) return $unsigned(sd >>> s);
        return d >> s;
    endfunction

    // Drive one cycle of inputs after the falling edge.
    // Then, just before the next rising edge, settle the handshakes against
    // the scoreboard.
    task automatic applyStimulus(input logic iv, input logic [31:0] d, input logic [4:0] s,
                                 input logic a, input logic ordy, input logic fl,
                                 input logic rst, input logic [31:0] exp_val);
        @(negedge clock);
        in_valid   = iv;
        data_input = d;
        shamt      = s;
        arith      = a;
        out_ready  = ordy;
        flush      = fl;
        reset      = rst;
        #1;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
        end else begin
            checkOutput("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (out_valid && out_ready) begin
                checkOutput("extra_result", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    checkOutput("result", data_output, exp_q.pop_front());
                    if (lat_check) checkOutput("latency", 32'(cyc - acc_q[0]), 32'd5);
                    void'(acc_q.pop_front());
                    results_seen++;
                end
            end
            if (fl) begin
                exp_q.delete();
                acc_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back(exp_val);
                acc_q.push_back(cyc);
            end
        end
        cyc++;
    endtask

    task automatic idleCycles(input int n, input logic ordy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, ordy, 1'b0, 1'b0, '0);
    endtask

    // Directed scenarios followed by a long randomized run.
    initial begin
        logic [31:0] d;
        logic [4:0]  s;
        logic        a;
        logic [31:0] hold_data;
        logic [31:0] first_exp;
        int          base;

        // Reset, then check the idle output state.
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1, '0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1, '0);
        idleCycles(1, 1'b1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_data", data_output, 32'h0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

        // Basic back-to-back operations, with latency checked.
        lat_check = 1'b1;
        base = results_seen;
        applyStimulus(1'b1, 32'h80000000, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 32'hF8000000);
        applyStimulus(1'b1, 32'h80000000, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 32'h08000000);
        applyStimulus(1'b1, 32'h12345678, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h12345678);
        // Extreme shift amounts.
        applyStimulus(1'b1, 32'hFFFFFFFF, 5'd31, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000001);
        applyStimulus(1'b1, 32'h80000000, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF);
        applyStimulus(1'b1, 32'h7FFFFFFF, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000);
        applyStimulus(1'b1, 32'hDEADBEEF, 5'd16, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000DEAD);
        idleCycles(7, 1'b1);
        checkOutput("basic_count", 32'(results_seen - base), 32'd7);
        lat_check = 1'b0;

        // Backpressure: seven ops against a stalled output, only five fit.
        first_exp = '0;
        for (int i = 0; i < 7; i++) begin
            d = $urandom;
            s = 5'($urandom_range(0, 31));
            a = 1'($urandom_range(0, 1));
            if (i == 0) first_exp = ref_shift(d, s, a);
            applyStimulus(1'b1, d, s, a, 1'b0, 1'b0, 1'b0, ref_shift(d, s, a));
            if (i >= 5) begin
                checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
                checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
            end
        end
        hold_data = data_output;
        checkOutput("stall_head", data_output, first_exp);
        for (int i = 0; i < 3; i++) begin
            idleCycles(1, 1'b0);
            checkOutput("stall_stable", data_output, hold_data);
            checkOutput("stall_valid_hold", 32'(out_valid), 32'd1);
        end
        base = results_seen;
        idleCycles(8, 1'b1);
        checkOutput("drain_count", 32'(results_seen - base), 32'd5);

        // Flush squashes three in-flight ops and the op presented with it.
        base = results_seen;
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            applyStimulus(1'b1, d, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, ref_shift(d, 5'd3, 1'b1));
        end
        idleCycles(1, 1'b1);
        applyStimulus(1'b1, 32'hCAFEF00D, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h657F7806);
        applyStimulus(1'b1, 32'hA5A5A5A5, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFA5A5A5);
        checkOutput("flush_quiet", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            idleCycles(1, 1'b1);
            checkOutput("flush_quiet", 32'(out_valid), 32'd0);
        end
        idleCycles(1, 1'b1);
        checkOutput("post_flush_valid", 32'(out_valid), 32'd1);
        checkOutput("flush_count", 32'(results_seen - base), 32'd1);

        // A reset in mid-stream drops everything in flight.
        for (int i = 0; i < 5; i++) begin
            d = $urandom;
            applyStimulus(1'b1, d, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, ref_shift(d, 5'd2, 1'b0));
        end
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1, '0);
        base = results_seen;
        idleCycles(1, 1'b1);
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_data", data_output, 32'h0);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
        idleCycles(8, 1'b1);
        checkOutput("midreset_count", 32'(results_seen - base), 32'd0);

        // Random traffic with random backpressure and occasional flushes.
        for (int i = 0; i < 10000; i++) begin
            d = $urandom;
            s = 5'($urandom_range(0, 31));
            a = 1'($urandom_range(0, 1));
            applyStimulus(1'($urandom_range(0, 9) < 7), d, s, a,
                          1'($urandom_range(0, 9) < 7),
                          1'($urandom_range(0, 199) == 0), 1'b0, ref_shift(d, s, a));
        end
        idleCycles(10, 1'b1);
        checkOutput("final_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
